// File: rtl/vermicom_bus_bridge_pkg.sv
// Shared constants and state encodings for the Vermicom debug bus bridge.
package Vermibridge_pkg;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK       = 8'h06;
    localparam logic [7:0] NAK       = 8'h15;
    localparam int BITS_PER_FRAME    = 10;

    typedef enum logic [2:0] {CMD_IDLE, CMD_ADDR, CMD_DATA, CMD_BUS, CMD_REPLY} cmd_state_e;
    typedef enum logic [1:0] {SD_IDLE, SD_BUSY, SD_DONE} serdes_state_e;
endpackage

// File: rtl/vermicom_bus_bridge_if.sv
// Vermibus initiator/responder signal bundle.
interface vermicom_bus_bridge_if;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (output valid, address, wstrobe, wdata, input rdata, ready);
    modport slave  (input valid, address, wstrobe, wdata, output rdata, ready);
endinterface

// File: rtl/vermicom_bus_bridge_serdes.sv
// 8N1 UART receiver and transmitter; one bit lasts DIVISION+1 clocks.
module vermicom_bridge_serdes
    import Vermibridge_pkg::*;
#(
    parameter int DIVISION = 867
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready
);
    localparam int CW = (DIVISION < 1) ? 1 : $clog2(DIVISION + 1);
    localparam logic [CW-1:0] HALF = CW'(DIVISION / 2);
    localparam logic [CW-1:0] LAST = CW'(DIVISION);

    serdes_state_e rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [1:0]    rx_sync_q, rx_sync_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [8:0]    tx_shift_q, tx_shift_d;
    logic          rx_valid_q, rx_valid_d, rx_error_q, rx_error_d, tx_q, tx_d;
    logic          rx_in;

    // rx is asynchronous to clk: two-flop synchroniser before any decision
    assign rx_in    = rx_sync_q[1];
    assign rx_data  = rx_shift_q;
    assign rx_valid = rx_valid_q;
    assign rx_error = rx_error_q;
    assign tx       = tx_q;
    assign tx_ready = (tx_state_q == SD_IDLE);

    always_comb begin
        rx_sync_d  = {rx_sync_q[0], rx};
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;
        case (rx_state_q)
            SD_IDLE: if (!rx_in) begin
                rx_state_d = SD_BUSY;
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
            end
            SD_BUSY: begin
                if (rx_cnt_q == HALF) begin
                    if (rx_bit_q == 4'(BITS_PER_FRAME - 1)) begin
                        rx_valid_d = rx_in;
                        rx_error_d = !rx_in;
                        rx_state_d = SD_DONE;
                    end else if (rx_bit_q != 4'd0) begin
                        rx_shift_d = {rx_in, rx_shift_q[7:1]};
                    end
                end
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d = '0;
                    rx_bit_d = rx_bit_q + 4'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            SD_DONE: if (rx_in) rx_state_d = SD_IDLE;
            default: rx_state_d = SD_IDLE;
        endcase
    end

    // tx_shift holds the bits still to go after the one on the line
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        case (tx_state_q)
            SD_IDLE: if (tx_start) begin
                tx_state_d = SD_BUSY;
                tx_shift_d = {1'b1, tx_data};
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_d       = 1'b0;
            end
            SD_BUSY: begin
                if (tx_cnt_q == LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 4'(BITS_PER_FRAME - 1)) begin
                        tx_state_d = SD_DONE;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 4'd1;
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            SD_DONE: tx_state_d = SD_IDLE;
            default: tx_state_d = SD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= SD_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
            tx_state_q <= SD_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_q       <= 1'b1;
        end else begin
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_error_q <= rx_error_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end
endmodule

// File: rtl/vermicom_bus_bridge.sv
// UART-driven Vermibus initiator: parses W/R commands, runs one bus transfer, replies.
module vermicom_bus_bridge
    import Vermibridge_pkg::*;
#(
    parameter int DIVISION = 867
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic tx,
    vermicom_bus_bridge_if.master bus
);
    cmd_state_e  state_q, state_d;
    logic        is_write_q, is_write_d, is_err_q, is_err_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] address_q, address_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]  rx_data, tx_data;
    logic        rx_valid, rx_error, tx_start, tx_ready;

    vermicom_bridge_serdes #(.DIVISION(DIVISION)) u_serdes (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .tx       (tx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_error (rx_error),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_ready (tx_ready)
    );

    assign bus.valid   = (state_q == CMD_BUS);
    assign bus.address = address_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrobe = (bus.valid && is_write_q) ? 4'hF : 4'h0;

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        is_err_d   = is_err_q;
        byte_cnt_d = byte_cnt_q;
        address_d  = address_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        tx_start   = 1'b0;
        tx_data    = NAK;
        case (state_q)
            CMD_IDLE: begin
                byte_cnt_d = 2'd0;
                if (rx_error) begin
                    is_err_d = 1'b1;
                    state_d  = CMD_REPLY;
                end else if (rx_valid) begin
                    is_err_d   = (rx_data != CMD_WRITE) && (rx_data != CMD_READ);
                    is_write_d = (rx_data == CMD_WRITE);
                    state_d    = is_err_d ? CMD_REPLY : CMD_ADDR;
                end
            end
            // Bytes arrive little-endian, so shift each one in from the top
            CMD_ADDR, CMD_DATA: begin
                if (rx_error) begin
                    is_err_d   = 1'b1;
                    byte_cnt_d = 2'd0;
                    state_d    = CMD_REPLY;
                end else if (rx_valid) begin
                    if (state_q == CMD_ADDR) address_d = {rx_data, address_q[31:8]};
                    else                     wdata_d   = {rx_data, wdata_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == CMD_ADDR && is_write_q) state_d = CMD_DATA;
                        else                                   state_d = CMD_BUS;
                    end
                end
            end
            CMD_BUS: if (bus.ready) begin
                if (!is_write_q) rdata_d = bus.rdata;
                state_d = CMD_REPLY;
            end
            CMD_REPLY: begin
                tx_start = 1'b1;
                if (is_err_q)        tx_data = NAK;
                else if (is_write_q) tx_data = ACK;
                else                 tx_data = rdata_q[{byte_cnt_q, 3'b000} +: 8];
                if (tx_ready) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (is_err_q || is_write_q || byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        state_d    = CMD_IDLE;
                    end
                end
            end
            default: state_d = CMD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= CMD_IDLE;
            is_write_q <= 1'b0;
            is_err_q   <= 1'b0;
            byte_cnt_q <= 2'd0;
            address_q  <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            is_err_q   <= is_err_d;
            byte_cnt_q <= byte_cnt_d;
            address_q  <= address_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_vermicom_bus_bridge.sv
// Directed bench for vermicom_bus_bridge: expected bus accesses and reply bytes go
// into queues; independent bus and UART monitors pop and compare.
`timescale 1ns/1ps
module tb_vermicom_bus_bridge;
    import Vermibridge_pkg::*;

    localparam int DIV = 3;
    localparam int BIT = DIV + 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic rx = 1'b1;
    logic tx;

    vermicom_bus_bridge_if bus();

    vermicom_bus_bridge #(.DIVISION(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .tx    (tx),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrobe;
        int          stall;
        logic [31:0] rdata;
    } bus_exp_t;

    bus_exp_t   exp_bus[$];
    logic [7:0] exp_tx[$];
    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Bus responder + monitor: ready is raised once the entry's stall count has elapsed
    int vcyc = 0;
    always @(negedge clk) begin
        if (!reset) begin
            bus.ready = 1'b0;
            bus.rdata = '0;
            vcyc = 0;
        end else if (bus.valid) begin
            vcyc++;
            if (exp_bus.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL bus_unexpected: valid=1 addr=%h wstrobe=%h, want no access", bus.address, bus.wstrobe);
                bus.ready = 1'b1;
            end else begin
                check("bus_addr", bus.address, exp_bus[0].addr);
                check("bus_wstrobe", 32'(bus.wstrobe), 32'(exp_bus[0].wstrobe));
                if (exp_bus[0].wstrobe == 4'hF) check("bus_wdata", bus.wdata, exp_bus[0].wdata);
                if (vcyc > exp_bus[0].stall) begin
                    bus.ready = 1'b1;
                    bus.rdata = exp_bus[0].rdata;
                    void'(exp_bus.pop_front());
                end else begin
                    bus.ready = 1'b0;
                end
            end
        end else begin
            bus.ready = 1'b0;
            vcyc = 0;
        end
    end

    // UART monitor: samples each tx bit mid-period
    always begin : tx_mon
        logic [7:0] b;
        @(negedge clk);
        if (reset && tx === 1'b0) begin
            repeat (2) @(negedge clk);
            check("tx_start_bit", 32'(tx), 32'd0);
            for (int k = 0; k < 8; k++) begin
                repeat (BIT) @(negedge clk);
                b[k] = tx;
            end
            repeat (BIT) @(negedge clk);
            check("tx_stop_bit", 32'(tx), 32'd1);
            if (exp_tx.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL tx_unexpected: frame %h, want no frame", b);
            end else begin
                check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stopb = 1'b1);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic expect_read_reply(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_tx.push_back(w[8*i +: 8]);
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_pending"}, 32'(exp_bus.size() + exp_tx.size()), 32'd0);
        exp_bus.delete();
        exp_tx.delete();
        repeat (60) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_address", bus.address, 32'd0);
        check("reset_wdata", bus.wdata, 32'd0);
        check("reset_wstrobe", 32'(bus.wstrobe), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // write with ready tied high
        exp_bus.push_back('{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0});
        exp_tx.push_back(ACK);
        send_byte(CMD_WRITE);
        send_word(32'h0000_0010);
        send_word(32'hDEAD_BEEF);
        wait_drain("write");

        // read with a 3-cycle stall
        exp_bus.push_back('{32'h0000_0020, 32'h0, 4'h0, 3, 32'h1234_5678});
        expect_read_reply(32'h1234_5678);
        send_byte(CMD_READ);
        send_word(32'h0000_0020);
        wait_drain("read_stall");

        // unknown command, then a normal read
        exp_tx.push_back(NAK);
        send_byte(8'h41);
        wait_drain("bad_cmd");
        exp_bus.push_back('{32'h0000_0000, 32'h0, 4'h0, 0, 32'hA5C3_0F81});
        expect_read_reply(32'hA5C3_0F81);
        send_byte(CMD_READ);
        send_word(32'h0000_0000);
        wait_drain("after_bad_cmd");

        // framing error on third address byte, then a normal read
        exp_tx.push_back(NAK);
        send_byte(CMD_WRITE);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30, 1'b0);
        repeat (4) @(negedge clk);
        wait_drain("framing");
        exp_bus.push_back('{32'h0000_0040, 32'h0, 4'h0, 0, 32'h0BAD_F00D});
        expect_read_reply(32'h0BAD_F00D);
        send_byte(CMD_READ);
        send_word(32'h0000_0040);
        wait_drain("after_framing");

        // a 'W' arriving during the read reply must be ignored
        exp_bus.push_back('{32'h0000_0050, 32'h0, 4'h0, 0, 32'h1122_3344});
        expect_read_reply(32'h1122_3344);
        send_byte(CMD_READ);
        send_word(32'h0000_0050);
        begin
            int t;
            t = 0;
            while (tx !== 1'b0 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            check("reply_started", 32'(t < 1000), 32'd1);
        end
        send_byte(CMD_WRITE);
        wait_drain("drop_in_reply");
        exp_bus.push_back('{32'h0000_0060, 32'h0, 4'h0, 0, 32'hCAFE_0042});
        expect_read_reply(32'hCAFE_0042);
        send_byte(CMD_READ);
        send_word(32'h0000_0060);
        wait_drain("after_drop");

        // reset while the bus request is stalled
        exp_bus.push_back('{32'h0000_0070, 32'h0, 4'h0, 1000000, 32'h0});
        send_byte(CMD_READ);
        send_word(32'h0000_0070);
        begin
            int t;
            t = 0;
            while (bus.valid !== 1'b1 && t < 1000) begin
                @(negedge clk);
                t++;
            end
            check("stall_valid_seen", 32'(t < 1000), 32'd1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset_valid", 32'(bus.valid), 32'd0);
        check("async_reset_tx", 32'(tx), 32'd1);
        exp_bus.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        exp_bus.push_back('{32'h0000_0080, 32'h0102_0304, 4'hF, 0, 32'h0});
        exp_tx.push_back(ACK);
        send_byte(CMD_WRITE);
        send_word(32'h0000_0080);
        send_word(32'h0102_0304);
        wait_drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", nmis);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vermicom_bus_bridge.md
Name: vermicom_bus_bridge

Overview:
- UART-to-Vermibus debug bridge: a bus initiator driven by a host over a serial line.
- It is the opposite end of the Vermicom link. A host sends read/write commands as UART frames; the bridge issues one Vermibus transaction per command and returns an acknowledge or the read data over UART.
- Sits beside the CPU as a second bus initiator, for loading and inspecting memory.

Parameters:
- DIVISION, 867, bit period minus one in clk cycles; one bit lasts DIVISION+1 cycles (same counting as Vermicom division_reg).

Ports:
- clk  input  1  system clock
- reset  input  1  reset; asynchronous, active-low
- rx  input  1  serial in from host, idle high
- tx  output  1  serial out to host, idle high
- valid  output  1  bus request
- address  output  32  bus address
- wstrobe  output  4  byte write enables; 4'b1111 for write, 4'b0000 for read
- wdata  output  32  bus write data
- rdata  input  32  bus read data
- ready  input  1  responder accepts/completes the request

Behaviour:
- Reset (reset low, asynchronous): tx=1, valid=0, address=0, wdata=0, wstrobe=0, all FSMs IDLE, counters cleared. Reset mid-frame or mid-transaction aborts with no bus access and no reply.
- UART framing, both directions: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- Receiver:
  - Leaves IDLE on rx=0.
  - Samples each bit when its bit counter equals DIVISION/2 (integer division).
  - After the stop sample: stop=1 delivers the byte with a 1-cycle rx_valid pulse; stop=0 is a framing error, 1-cycle rx_error pulse, byte discarded.
  - Returns to IDLE once rx=1.
- Transmitter:
  - Accepts a byte only when idle (tx_ready=1).
  - Drives tx=0 on the cycle after acceptance.
  - Emits 10 bits of DIVISION+1 cycles each, then one DONE cycle before tx_ready returns.
- Command FSM states: IDLE, ADDR, DATA, BUS, REPLY.
  - IDLE, on byte:
    - 0x57 'W': go to ADDR with write flag set.
    - 0x52 'R': go to ADDR with write flag clear.
    - Any other byte: queue NAK 0x15, go to REPLY.
  - ADDR: collect 4 bytes, little-endian, into address. Then write → DATA, read → BUS.
  - DATA: collect 4 bytes, little-endian, into wdata, then BUS.
  - BUS:
    - valid=1 with address/wdata/wstrobe stable; hold all of them until a cycle with ready=1.
    - That cycle is the transfer; valid=0 on the next cycle.
    - A read captures rdata on the transfer cycle.
    - Next state REPLY.
  - REPLY:
    - Write: send ACK 0x06.
    - Read: send 4 data bytes, little-endian.
    - Error: send NAK 0x15.
    - Return to IDLE once the last byte is accepted by the transmitter.
- Bytes received in BUS or REPLY are dropped.
- rx_error in ADDR or DATA: abort the command, send NAK, no bus access. rx_error in IDLE: NAK.
- Byte counter is 2 bits and wraps from 3 to 0 on state exit.
- Minimum latency from the last write-data stop sample to valid=1: 2 cycles.
- No inter-byte timeout.

Decomposition:
- Package Vermibridge_pkg holds:
  - CMD_WRITE=8'h57, CMD_READ=8'h52, ACK=8'h06, NAK=8'h15
  - command FSM state enum
  - serdes state enum (IDLE, BUSY, DONE)
  - BITS_PER_FRAME=10
- Sub-module vermicom_bridge_serdes contains the UART receiver and transmitter.
  - Ports: clk, reset, rx, tx, rx_data, rx_valid, rx_error, tx_data, tx_start, tx_ready.
  - Parameter: DIVISION.

Test Plan (DIVISION=3, bit = 4 cycles):
- Write: host sends 57 10 00 00 00 EF BE AD DE, ready tied 1 → exactly one cycle with valid=1, address=0x00000010, wdata=0xDEADBEEF, wstrobe=4'hF; then tx frame 0x06.
- Read with stall: host sends 52 20 00 00 00, ready low 3 cycles then high with rdata=0x12345678 → valid high 4 cycles, address/wstrobe=0 stable; tx frames 78 56 34 12 in order.
- Bad command: host sends 0x41 → no valid; tx frame 0x15; next 52 00 00 00 00 executes normally.
- Framing error: write command whose third address byte has stop bit 0 → no bus access; tx 0x15; FSM back in IDLE.
- Bytes during reply: during read reply, host sends 0x57 → dropped; no bus access afterwards.
- Reset mid-transaction: assert reset while valid=1 and ready=0 → valid=0 and tx=1 immediately (asynchronous); after release, no reply frame, next command works.
